block_data_memory: RTL

- Block-granular data memory; the responder side of the cache/memory read-write-busywait handshake that the CPU's data cache initiates.
- Serves whole-block line fills (read) and write-backs (write) with a fixed, configurable access latency. This models the main memory behind the cache that the context-switch cache work swaps.
- Sits below the data cache inside the cpu hierarchy; single clock domain.

---
 rtl/block_data_memory.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/block_data_memory.sv
// Block-granular data memory. It answers the data cache's read/write/busywait
// handshake with whole-block fills and write-backs after a fixed LATENCY.
// Optional build macro BLOCK_MEM_STATS_EN adds rd_count/wr_count completion
// counters.
module block_data_memory #(
  parameter int ADDR_W  = 6,
  parameter int BLOCK_W = 128,
  parameter int LATENCY = 40
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [ADDR_W-1:0]  mem_address,
  input  logic [BLOCK_W-1:0] mem_writedata,
  output logic [BLOCK_W-1:0] mem_readdata,
  output logic               mem_busywait,
  output logic               mem_err
`ifdef BLOCK_MEM_STATS_EN
  ,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic [BLOCK_W-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               req;
  logic               complete;

  logic [BLOCK_W-1:0] mem_q [2**ADDR_W];

  assign req = mem_read | mem_write;

  // Next-state logic: accept in IDLE, count down in BUSY, one-cycle DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = mem_address;
          wr_d    = mem_write;
          wdata_d = mem_writedata;
          cnt_d   = LAT_M1;
          state_d = BUSY;
          if (mem_read && mem_write) begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          // Initiator withdrew: abandon without commit.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 8'd1) begin
          // The counter reaches zero on this edge, E0+LATENCY-1 after acceptance.
          state_d  = DONE;
          cnt_d    = '0;
          complete = 1'b1;
          if (!wr_q) begin
            rdata_d = mem_q[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; async active-low reset aborts any access.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array; not cleared by reset, written only when a write completes.
  always_ff @(posedge CLK) begin
    if (complete && wr_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  // Stall while a request waits in IDLE or an access is in flight; never in reset.
  always_comb begin
    mem_busywait = 1'b0;
    if (RESET) begin
      mem_busywait = (state_q == BUSY) || ((state_q == IDLE) && req);
    end
  end

  assign mem_readdata = rdata_q;
  assign mem_err      = err_q;

`ifdef BLOCK_MEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  // Saturating completion counters; aborted accesses never reach DONE.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (complete) begin
      if (wr_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule
